bus_ic: RTL and testbench

//  Parametrised single-master bus interconnect; next generation of the hard-wired top-level address decoder.

---
 rtl/bus_ic_pkg.sv | 23 ++
 rtl/bus_ic_addr_match.sv | 40 ++++
 rtl/bus_ic.sv | 194 +++++++++++++++++++
 tb/tb_bus_ic.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_ic_pkg.sv
// bus_ic_pkg
//   Shared definitions for the bus interconnect: FSM state encoding,
//   fault cause codes and a helper for sizing the slave-select index.
package bus_ic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_UNMAPPED = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } cause_t;

  // Width of a slave index; a single-slave build still gets a 1-bit index.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_ic_addr_match.sv
// bus_ic_addr_match
//   Combinational address decoder: one base/mask comparator per slave,
//   followed by a priority encoder where the lowest index wins.
// Ports
//   addr    in   AW     master word address
//   hit     out  1      at least one window matches
//   sel     out  SW     index of the winning window (0 when no hit)
//   onehot  out  NSLV   one-hot of the winning window (zero when no hit)
module bus_ic_addr_match
  import bus_ic_pkg::*;
#(
  parameter int                 NSLV     = 8,
  parameter int                 AW       = 22,
  parameter int                 SW       = 3,
  parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK = '1
) (
  input  logic [AW-1:0]   addr,
  output logic            hit,
  output logic [SW-1:0]   sel,
  output logic [NSLV-1:0] onehot
);

  // Walk from the highest index down so the lowest matching window is the
  // last one written and therefore wins on overlaps.
  always_comb begin
    hit    = 1'b0;
    sel    = '0;
    onehot = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit       = 1'b1;
        sel       = SW'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_ic.sv
// bus_ic
//   Single-master bus interconnect. Decodes the CPU word address against
//   NSLV base/mask windows, routes strobe, read data and acknowledge with no
//   added latency, and answers with a bus error for unmapped addresses or
//   when the selected slave does not acknowledge within TMO_CYCLES waits.
//   The first fault is captured in a sticky register; later faults only set
//   the overflow flag until software clears it.
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   m_stb/m_we/m_addr master request (strobe held until m_ack)
//   m_din/m_ack/m_err master response (m_err valid only with m_ack)
//   s_stb             per-slave strobe, one-hot or zero
//   s_din/s_ack       per-slave read data (packed) and acknowledge
//   flt_clr           clear fault valid/overflow
//   flt_valid/flt_cause/flt_we/flt_addr/flt_ovf  captured fault
module bus_ic
  import bus_ic_pkg::*;
#(
  parameter int                 NSLV       = 8,
  parameter int                 AW         = 22,
  parameter int                 DW         = 32,
  parameter logic [NSLV*AW-1:0] SLV_BASE   = '0,
  parameter logic [NSLV*AW-1:0] SLV_MASK   = '1,
  parameter int                 TMO_CYCLES = 255,
  parameter logic [DW-1:0]      ERR_DATA   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_stb,
  input  logic              m_we,
  input  logic [AW-1:0]     m_addr,
  output logic [DW-1:0]     m_din,
  output logic              m_ack,
  output logic              m_err,
  output logic [NSLV-1:0]   s_stb,
  input  logic [NSLV*DW-1:0] s_din,
  input  logic [NSLV-1:0]   s_ack,
  input  logic              flt_clr,
  output logic              flt_valid,
  output logic [1:0]        flt_cause,
  output logic              flt_we,
  output logic [AW-1:0]     flt_addr,
  output logic              flt_ovf
);

  localparam int SW = sel_width(NSLV);
  localparam int CW = $clog2(TMO_CYCLES + 1);

  state_t          state;
  logic [CW-1:0]   cnt;

  logic            hit;
  logic [SW-1:0]   sel;
  logic [NSLV-1:0] onehot;

  logic            sel_ack;
  logic [DW-1:0]   sel_din;
  logic            tmo_hit;
  logic            err_entry;
  cause_t          err_cause;

  bus_ic_addr_match #(
    .NSLV     (NSLV),
    .AW       (AW),
    .SW       (SW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_match (
    .addr   (m_addr),
    .hit    (hit),
    .sel    (sel),
    .onehot (onehot)
  );

  // Pick the selected slave's data and acknowledge.
  always_comb begin
    sel_ack = 1'b0;
    sel_din = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel == SW'(i)) begin
        sel_ack = s_ack[i];
        sel_din = s_din[i*DW +: DW];
      end
    end
  end

  assign tmo_hit = (cnt == CW'(TMO_CYCLES));

  // Conditions that move the FSM into ERR on the next edge. A master abort
  // in WAIT takes precedence over a timeout in the same cycle.
  always_comb begin
    err_entry = 1'b0;
    err_cause = CAUSE_UNMAPPED;
    case (state)
      ST_IDLE: begin
        if (m_stb && !hit) begin
          err_entry = 1'b1;
          err_cause = CAUSE_UNMAPPED;
        end
      end
      ST_WAIT: begin
        if (m_stb && !(hit && sel_ack) && tmo_hit) begin
          err_entry = 1'b1;
          err_cause = CAUSE_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // Master-side response and slave strobes. Routing is combinational so a
  // zero-wait slave completes in the strobe cycle. Everything is forced
  // quiet while reset is held, independent of the decoded address.
  always_comb begin
    s_stb = '0;
    m_ack = 1'b0;
    m_err = 1'b0;
    m_din = '0;
    if (!rst) begin
      if (state == ST_ERR) begin
        m_ack = 1'b1;
        m_err = 1'b1;
        m_din = ERR_DATA;
      end else if (m_stb && hit) begin
        s_stb = onehot;
        m_ack = sel_ack;
        m_din = sel_din;
      end
    end
  end

  // Transfer FSM and wait counter. The counter stops at TMO_CYCLES because
  // reaching it always leaves WAIT, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (err_entry) begin
            state <= ST_ERR;
          end else if (m_stb && !sel_ack) begin
            state <= ST_WAIT;
            cnt   <= CW'(1);
          end
        end
        ST_WAIT: begin
          if (!m_stb || (hit && sel_ack)) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (err_entry) begin
            state <= ST_ERR;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ERR: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Sticky fault capture. A new fault in the same cycle as a clear is
  // treated as the first fault after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_valid <= 1'b0;
      flt_cause <= CAUSE_NONE;
      flt_we    <= 1'b0;
      flt_addr  <= '0;
      flt_ovf   <= 1'b0;
    end else if (err_entry && (!flt_valid || flt_clr)) begin
      flt_valid <= 1'b1;
      flt_cause <= err_cause;
      flt_we    <= m_we;
      flt_addr  <= m_addr;
      flt_ovf   <= 1'b0;
    end else if (err_entry) begin
      flt_ovf <= 1'b1;
    end else if (flt_clr) begin
      flt_valid <= 1'b0;
      flt_ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_ic.sv
// tb_bus_ic
//   Self-checking bench for bus_ic with four slaves (PROM, RAM, TMR, SER)
//   and a four-cycle timeout. Slaves are modelled by a per-slave ack delay;
//   expected responses go into a scoreboard queue when a transfer starts and
//   are popped when the master sees m_ack.
module tb_bus_ic;
  import bus_ic_pkg::*;

  localparam int NSLV = 4;
  localparam int AW   = 22;
  localparam int DW   = 32;
  localparam int TMO  = 4;
  localparam int MAX_WAIT = 20;
  localparam logic [NSLV*AW-1:0] BASES = {22'h3FFFF2, 22'h3FFFF0, 22'h000000, 22'h3FF800};
  localparam logic [NSLV*AW-1:0] MASKS = {22'h3FFFFE, 22'h3FFFFF, 22'h3FF800, 22'h3FFE00};
  localparam logic [DW-1:0] ERR_D = 32'h0;

  logic              clk = 1'b0;
  logic              rst;
  logic              m_stb, m_we;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_din;
  logic              m_ack, m_err;
  logic [NSLV-1:0]   s_stb;
  logic [NSLV*DW-1:0] s_din;
  logic [NSLV-1:0]   s_ack;
  logic              flt_clr;
  logic              flt_valid;
  logic [1:0]        flt_cause;
  logic              flt_we;
  logic [AW-1:0]     flt_addr;
  logic              flt_ovf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } exp_t;
  exp_t sb[$];

  int              ack_delay [NSLV];
  int              stb_age   [NSLV];
  logic [NSLV-1:0] force_ack;

  always #5 clk = ~clk;

  bus_ic #(
    .NSLV(NSLV), .AW(AW), .DW(DW), .SLV_BASE(BASES), .SLV_MASK(MASKS),
    .TMO_CYCLES(TMO), .ERR_DATA(ERR_D)
  ) dut (
    .clk(clk), .rst(rst), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
    .m_din(m_din), .m_ack(m_ack), .m_err(m_err), .s_stb(s_stb),
    .s_din(s_din), .s_ack(s_ack), .flt_clr(flt_clr), .flt_valid(flt_valid),
    .flt_cause(flt_cause), .flt_we(flt_we), .flt_addr(flt_addr), .flt_ovf(flt_ovf)
  );

  assign s_din = {32'h5E5E0003, 32'h7A770002, 32'hCAFE0001, 32'h12345678};

  // Slave model: slave i acks once its strobe has been high ack_delay[i]
  // cycles (negative delay = never acks). force_ack injects stray acks.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NSLV; i++) begin
      if (rst) stb_age[i] <= 0;
      else if (s_stb[i] && !s_ack[i]) stb_age[i] <= stb_age[i] + 1;
      else stb_age[i] <= 0;
    end
  end

  always_comb begin
    s_ack = force_ack;
    for (int i = 0; i < NSLV; i++)
      if (s_stb[i] && ack_delay[i] >= 0 && stb_age[i] == ack_delay[i]) s_ack[i] = 1'b1;
  end

  task automatic start_txn(input logic [AW-1:0] addr, input logic we);
    m_addr = addr;
    m_we   = we;
    m_stb  = 1'b1;
  endtask

  task automatic end_txn();
    @(posedge clk); #1;
    m_stb = 1'b0;
    m_we  = 1'b0;
  endtask

  // Called one step after a rising edge; returns at the falling edge of the
  // cycle where m_ack was seen (or after MAX_WAIT cycles without one).
  task automatic wait_ack(output bit got, output int lat, output logic [DW-1:0] din,
                          output logic err, output logic [NSLV-1:0] stb_or,
                          output logic [NSLV-1:0] stb_at_ack);
    got = 1'b0; lat = 0; din = '0; err = 1'b0; stb_or = '0; stb_at_ack = '0;
    for (int c = 0; c <= MAX_WAIT; c++) begin
      @(negedge clk);
      stb_or |= s_stb;
      if (m_ack) begin
        got = 1'b1; lat = c; din = m_din; err = m_err; stb_at_ack = s_stb;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; m_stb = 1'b1; m_addr = 22'h000010; ack_delay[1] = 0;
    repeat (2) @(negedge clk);
    checks++; if (s_stb !== 4'b0000) begin failures++; $display("[TB] FAIL reset_s_stb got=%b exp=0000", s_stb); end
    checks++; if (m_ack !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_ack got=%b exp=0", m_ack); end
    checks++; if (m_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_err got=%b exp=0", m_err); end
    checks++; if ({flt_valid, flt_ovf, flt_we, flt_cause} !== 5'b0) begin failures++; $display("[TB] FAIL reset_flt got=%b exp=00000", {flt_valid, flt_ovf, flt_we, flt_cause}); end
    checks++; if (flt_addr !== 22'h0) begin failures++; $display("[TB] FAIL reset_flt_addr got=%h exp=0", flt_addr); end
    m_stb = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=%0d", dut.state, ST_IDLE); end
    checks++; if (dut.cnt !== 0) begin failures++; $display("[TB] FAIL reset_cnt got=%0d exp=0", dut.cnt); end
  endtask

  task automatic test_prom_read();
    bit got; int lat; logic [DW-1:0] din; logic err; logic [NSLV-1:0] so, sa; exp_t e;
    ack_delay[0] = 0;
    @(posedge clk); #1;
    sb.push_back('{32'h12345678, 1'b0, 0});
    start_txn(22'h3FF800, 1'b0);
    wait_ack(got, lat, din, err, so, sa);
    e = sb.pop_front();
    checks++; if (!got) begin failures++; $display("[TB] FAIL prom_ack got=none exp=ack"); end
    checks++; if (din !== e.data) begin failures++; $display("[TB] FAIL prom_data got=%h exp=%h", din, e.data); end
    checks++; if (err !== e.err || lat != e.lat) begin failures++; $display("[TB] FAIL prom_err_lat got=%b/%0d exp=%b/%0d", err, lat, e.err, e.lat); end
    checks++; if (sa !== 4'b0001) begin failures++; $display("[TB] FAIL prom_s_stb got=%b exp=0001", sa); end
    end_txn();
    @(negedge clk);
    checks++; if (dut.state !== ST_IDLE) begin failures++; $display("[TB] FAIL prom_state got=%0d exp=%0d", dut.state, ST_IDLE); end
    checks++; if (m_din !== 32'h0 || m_ack !== 1'b0) begin failures++; $display("[TB] FAIL prom_idle_out got=%h/%b exp=0/0", m_din, m_ack); end
  endtask

  task automatic test_ram_wait();
    bit got; int lat; logic [DW-1:0] din; logic err; logic [NSLV-1:0] so, sa; exp_t e;
    ack_delay[1] = 3;
    @(posedge clk); #1;
    sb.push_back('{32'hCAFE0001, 1'b0, 3});
    start_txn(22'h000123, 1'b0);
    wait_ack(got, lat, din, err, so, sa);
    e = sb.pop_front();
    checks++; if (!got) begin failures++; $display("[TB] FAIL ram_ack got=none exp=ack"); end
    checks++; if (din !== e.data || err !== e.err) begin failures++; $display("[TB] FAIL ram_data got=%h/%b exp=%h/%b", din, err, e.data, e.err); end
    checks++; if (lat != e.lat) begin failures++; $display("[TB] FAIL ram_latency got=%0d exp=%0d", lat, e.lat); end
    checks++; if (so !== 4'b0010) begin failures++; $display("[TB] FAIL ram_s_stb got=%b exp=0010", so); end
    end_txn();
    @(negedge clk);
    checks++; if (dut.cnt !== 0 || dut.state !== ST_IDLE) begin failures++; $display("[TB] FAIL ram_cnt_state got=%0d/%0d exp=0/%0d", dut.cnt, dut.state, ST_IDLE); end
  endtask

  task automatic test_unmapped();
    bit got; int lat; logic [DW-1:0] din; logic err; logic [NSLV-1:0] so, sa; exp_t e;
    @(posedge clk); #1;
    sb.push_back('{ERR_D, 1'b1, 1});
    start_txn(22'h3FFFF1, 1'b0);
    wait_ack(got, lat, din, err, so, sa);
    e = sb.pop_front();
    checks++; if (!got) begin failures++; $display("[TB] FAIL unmapped_ack got=none exp=ack"); end
    checks++; if (din !== e.data || err !== e.err) begin failures++; $display("[TB] FAIL unmapped_resp got=%h/%b exp=%h/%b", din, err, e.data, e.err); end
    checks++; if (lat != e.lat) begin failures++; $display("[TB] FAIL unmapped_latency got=%0d exp=%0d", lat, e.lat); end
    checks++; if (so !== 4'b0000) begin failures++; $display("[TB] FAIL unmapped_s_stb got=%b exp=0000", so); end
    checks++; if (flt_valid !== 1'b1 || flt_cause !== 2'b01 || flt_ovf !== 1'b0) begin failures++; $display("[TB] FAIL unmapped_flt got=%b/%b/%b exp=1/01/0", flt_valid, flt_cause, flt_ovf); end
    checks++; if (flt_addr !== 22'h3FFFF1 || flt_we !== 1'b0) begin failures++; $display("[TB] FAIL unmapped_flt_addr got=%h/%b exp=3ffff1/0", flt_addr, flt_we); end
    end_txn();
  endtask

  task automatic test_timeout_ovf();
    bit got; int lat; logic [DW-1:0] din; logic err; logic [NSLV-1:0] so, sa; exp_t e;
    ack_delay[3] = -1;
    @(posedge clk); #1;
    sb.push_back('{ERR_D, 1'b1, TMO + 1});
    start_txn(22'h3FFFF2, 1'b1);
    fork
      wait_ack(got, lat, din, err, so, sa);
      begin
        repeat (TMO + 1) @(posedge clk);
        #1 force_ack = 4'b1000;
      end
    join
    e = sb.pop_front();
    checks++; if (!got) begin failures++; $display("[TB] FAIL tmo_ack got=none exp=ack"); end
    checks++; if (din !== e.data || err !== e.err) begin failures++; $display("[TB] FAIL tmo_resp got=%h/%b exp=%h/%b", din, err, e.data, e.err); end
    checks++; if (lat != e.lat) begin failures++; $display("[TB] FAIL tmo_latency got=%0d exp=%0d", lat, e.lat); end
    checks++; if (sa !== 4'b0000 || so !== 4'b1000) begin failures++; $display("[TB] FAIL tmo_s_stb got=%b/%b exp=0000/1000", sa, so); end
    checks++; if (flt_valid !== 1'b1 || flt_ovf !== 1'b1) begin failures++; $display("[TB] FAIL tmo_ovf got=%b/%b exp=1/1", flt_valid, flt_ovf); end
    checks++; if (flt_addr !== 22'h3FFFF1 || flt_cause !== 2'b01 || flt_we !== 1'b0) begin failures++; $display("[TB] FAIL tmo_flt_kept got=%h/%b/%b exp=3ffff1/01/0", flt_addr, flt_cause, flt_we); end
    end_txn();
    force_ack = '0;

    // Clear coinciding with a new timeout: the new fault must be captured.
    @(posedge clk); #1;
    sb.push_back('{ERR_D, 1'b1, TMO + 1});
    start_txn(22'h3FFFF3, 1'b1);
    fork
      wait_ack(got, lat, din, err, so, sa);
      begin
        repeat (TMO) @(posedge clk);
        #1 flt_clr = 1'b1;
        @(posedge clk);
        #1 flt_clr = 1'b0;
      end
    join
    e = sb.pop_front();
    checks++; if (!got || err !== e.err || lat != e.lat) begin failures++; $display("[TB] FAIL clr_tmo_resp got=%b/%b/%0d exp=1/%b/%0d", got, err, lat, e.err, e.lat); end
    checks++; if (flt_valid !== 1'b1 || flt_cause !== 2'b10 || flt_ovf !== 1'b0) begin failures++; $display("[TB] FAIL clr_tmo_flt got=%b/%b/%b exp=1/10/0", flt_valid, flt_cause, flt_ovf); end
    checks++; if (flt_addr !== 22'h3FFFF3 || flt_we !== 1'b1) begin failures++; $display("[TB] FAIL clr_tmo_addr got=%h/%b exp=3ffff3/1", flt_addr, flt_we); end
    end_txn();

    @(posedge clk); #1 flt_clr = 1'b1;
    @(posedge clk); #1 flt_clr = 1'b0;
    @(negedge clk);
    checks++; if (flt_valid !== 1'b0 || flt_ovf !== 1'b0) begin failures++; $display("[TB] FAIL flt_clear got=%b/%b exp=0/0", flt_valid, flt_ovf); end
  endtask

  task automatic test_reset_in_wait();
    ack_delay[1] = -1;
    @(posedge clk); #1;
    start_txn(22'h000040, 1'b0);
    repeat (3) @(negedge clk);
    checks++; if (dut.cnt !== 2 || s_stb !== 4'b0010) begin failures++; $display("[TB] FAIL rstw_pre got=%0d/%b exp=2/0010", dut.cnt, s_stb); end
    rst = 1'b1;
    #1;
    checks++; if (s_stb !== 4'b0000 || m_ack !== 1'b0 || m_err !== 1'b0) begin failures++; $display("[TB] FAIL rstw_drop got=%b/%b/%b exp=0000/0/0", s_stb, m_ack, m_err); end
    m_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (dut.state !== ST_IDLE || dut.cnt !== 0) begin failures++; $display("[TB] FAIL rstw_after got=%0d/%0d exp=%0d/0", dut.state, dut.cnt, ST_IDLE); end
  endtask

  task automatic test_abort();
    bit got; int lat; logic [DW-1:0] din; logic err; logic [NSLV-1:0] so, sa; exp_t e;
    int spurious;
    ack_delay[2] = -1;
    @(posedge clk); #1;
    start_txn(22'h3FFFF0, 1'b0);
    repeat (3) @(posedge clk);
    #1 m_stb = 1'b0;
    @(negedge clk);
    checks++; if (dut.cnt !== 3 || m_ack !== 1'b0 || m_din !== 32'h0) begin failures++; $display("[TB] FAIL abort_cycle got=%0d/%b/%h exp=3/0/0", dut.cnt, m_ack, m_din); end
    spurious = 0;
    for (int c = 0; c < TMO + 3; c++) begin
      @(negedge clk);
      if (m_ack || m_err) spurious++;
    end
    checks++; if (spurious != 0) begin failures++; $display("[TB] FAIL abort_no_ack got=%0d exp=0", spurious); end
    checks++; if (dut.state !== ST_IDLE || dut.cnt !== 0 || flt_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_state got=%0d/%0d/%b exp=%0d/0/0", dut.state, dut.cnt, flt_valid, ST_IDLE); end

    ack_delay[2] = 1;
    @(posedge clk); #1;
    sb.push_back('{32'h7A770002, 1'b0, 1});
    start_txn(22'h3FFFF0, 1'b0);
    wait_ack(got, lat, din, err, so, sa);
    e = sb.pop_front();
    checks++; if (!got || din !== e.data || err !== e.err || lat != e.lat) begin failures++; $display("[TB] FAIL abort_next got=%b/%h/%b/%0d exp=1/%h/%b/%0d", got, din, err, lat, e.data, e.err, e.lat); end
    end_txn();
  endtask

  task automatic test_back_to_back();
    bit got; int lat; logic [DW-1:0] din; logic err; logic [NSLV-1:0] so, sa; exp_t e;
    logic [AW-1:0]   addr_t [5] = '{22'h3FF800, 22'h000200, 22'h3FFFF1, 22'h3FFFF3, 22'h3FF9FC};
    logic [DW-1:0]   data_t [5] = '{32'h12345678, 32'hCAFE0001, ERR_D, 32'h5E5E0003, 32'h12345678};
    logic            err_t  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int              lat_t  [5] = '{0, 2, 1, 0, 0};
    logic [NSLV-1:0] stb_t  [5] = '{4'b0001, 4'b0010, 4'b0000, 4'b1000, 4'b0001};
    ack_delay[0] = 0; ack_delay[1] = 2; ack_delay[3] = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{data_t[i], err_t[i], lat_t[i]});
      start_txn(addr_t[i], 1'b0);
      wait_ack(got, lat, din, err, so, sa);
      e = sb.pop_front();
      checks++; if (!got || din !== e.data || err !== e.err || lat != e.lat) begin failures++; $display("[TB] FAIL b2b_%0d got=%b/%h/%b/%0d exp=1/%h/%b/%0d", i, got, din, err, lat, e.data, e.err, e.lat); end
      checks++; if (sa !== stb_t[i]) begin failures++; $display("[TB] FAIL b2b_stb_%0d got=%b exp=%b", i, sa, stb_t[i]); end
      @(posedge clk); #1;
    end
    m_stb = 1'b0;
    @(negedge clk);
    checks++; if (flt_valid !== 1'b1 || flt_cause !== 2'b01 || flt_addr !== 22'h3FFFF1) begin failures++; $display("[TB] FAIL b2b_flt got=%b/%b/%h exp=1/01/3ffff1", flt_valid, flt_cause, flt_addr); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; m_stb = 1'b0; m_we = 1'b0; m_addr = '0; flt_clr = 1'b0; force_ack = '0;
    for (int i = 0; i < NSLV; i++) ack_delay[i] = -1;
    $display("[TB] starting bus_ic bench");
    test_reset();
    test_prom_read();
    test_ram_wait();
    test_unmapped();
    test_timeout_ovf();
    test_reset_in_wait();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
